csr_access_ctrl: RTL and testbench

//   Zicsr execution controller, directly upstream of the csr register file: accepts CSRRW/RS/RC[I]

---
 rtl/csr_access_ctrl.sv | 154 +++++++++++++++
 tb/tb_csr_access_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_access_ctrl.sv
// rtl/csr_access_ctrl.sv - Zicsr read-modify-write controller in front of the csr register file
// Four-cycle IDLE/READ/WRITE/RESP sequence; illegal accesses go straight to RESP with no side effects.
module csr_access_ctrl #(
   parameter int XLEN     = 32,
   parameter int CSR_AW   = 12,
   parameter int RO_CHECK = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic [31:0]       instr,
   input  logic [XLEN-1:0]   rs1_val,
   output logic [CSR_AW-1:0] csr_addr,
   input  logic [XLEN-1:0]   csr_rdata,
   output logic              csr_we,
   output logic [XLEN-1:0]   csr_wd,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [4:0]        res_rd,
   output logic              res_rd_we,
   output logic [XLEN-1:0]   res_data,
   output logic              res_illegal
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_WRITE = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [CSR_AW-1:0]   addr_q, addr_d;
   logic [4:0]          rd_q, rd_d;
   logic [1:0]          op_q, op_d;
   logic [XLEN-1:0]     src_q, src_d;
   logic                wneed_q, wneed_d;
   logic                ill_q, ill_d;
   logic [XLEN-1:0]     old_q, old_d;

   logic [2:0]          dec_funct3;
   logic [4:0]          dec_rs1;
   logic [CSR_AW-1:0]   dec_addr;
   logic                dec_fmt_ok;
   logic                dec_wneed;
   logic                dec_ro_hit;
   logic                dec_legal;
   logic [XLEN-1:0]     dec_src;

   always_comb begin
      dec_funct3 = instr[14:12];
      dec_rs1    = instr[19:15];
      dec_addr   = instr[31:32-CSR_AW];
      dec_fmt_ok = (instr[6:0] == 7'b1110011) &&
                   (dec_funct3 != 3'b000) && (dec_funct3 != 3'b100);
      // funct3[1:0]==01 is CSRRW/CSRRWI, which always writes; set/clear with x0/uimm 0 only read
      dec_wneed  = (dec_funct3[1:0] == 2'b01) || (dec_rs1 != 5'd0);
      dec_ro_hit = (RO_CHECK != 0) && dec_wneed &&
                   (dec_addr[CSR_AW-1:CSR_AW-2] == 2'b11);
      dec_legal  = dec_fmt_ok && !dec_ro_hit;
      dec_src    = dec_funct3[2] ? {{(XLEN-5){1'b0}}, dec_rs1} : rs1_val;
   end

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      rd_d        = rd_q;
      op_d        = op_q;
      src_d       = src_q;
      wneed_d     = wneed_q;
      ill_d       = ill_q;
      old_d       = old_q;
      instr_ready = 1'b0;
      csr_we      = 1'b0;
      csr_wd      = '0;
      res_valid   = 1'b0;
      res_rd_we   = 1'b0;
      res_illegal = 1'b0;

      case (state_q)
         S_IDLE: begin
            instr_ready = 1'b1;
            if (instr_valid) begin
               rd_d = instr[11:7];
               if (dec_legal) begin
                  addr_d  = dec_addr;
                  op_d    = dec_funct3[1:0];
                  src_d   = dec_src;
                  wneed_d = dec_wneed;
                  ill_d   = 1'b0;
                  state_d = S_READ;
               end else begin
                  ill_d   = 1'b1;
                  old_d   = '0;
                  state_d = S_RESP;
               end
            end
         end
         S_READ: begin
            old_d   = csr_rdata;
            state_d = S_WRITE;
         end
         S_WRITE: begin
            csr_we = wneed_q;
            if (wneed_q) begin
               case (op_q)
                  2'b01:   csr_wd = src_q;
                  2'b10:   csr_wd = old_q | src_q;
                  2'b11:   csr_wd = old_q & ~src_q;
                  default: csr_wd = '0;
               endcase
            end
            state_d = S_RESP;
         end
         S_RESP: begin
            res_valid   = 1'b1;
            res_rd_we   = (rd_q != 5'd0) && !ill_q;
            res_illegal = ill_q;
            if (res_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign csr_addr = addr_q;
   assign res_rd   = rd_q;
   assign res_data = old_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         rd_q    <= '0;
         op_q    <= '0;
         src_q   <= '0;
         wneed_q <= 1'b0;
         ill_q   <= 1'b0;
         old_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         rd_q    <= rd_d;
         op_q    <= op_d;
         src_q   <= src_d;
         wneed_q <= wneed_d;
         ill_q   <= ill_d;
         old_q   <= old_d;
      end
   end

endmodule

// File: tb/tb_csr_access_ctrl.sv
// tb/tb_csr_access_ctrl.sv - directed bench for csr_access_ctrl with an instruction-level model
// Model derives per-instruction results; one negedge process compares every cycle.
module tb_csr_access_ctrl;

   logic        clk;
   logic        rst;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] rs1_val;
   logic [11:0] csr_addr;
   logic [31:0] csr_rdata;
   logic        csr_we;
   logic [31:0] csr_wd;
   logic        res_valid;
   logic        res_ready;
   logic [4:0]  res_rd;
   logic        res_rd_we;
   logic [31:0] res_data;
   logic        res_illegal;

   csr_access_ctrl #(.XLEN(32), .CSR_AW(12), .RO_CHECK(1)) dut (
      .clk(clk), .rst(rst),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .rs1_val(rs1_val),
      .csr_addr(csr_addr), .csr_rdata(csr_rdata), .csr_we(csr_we), .csr_wd(csr_wd),
      .res_valid(res_valid), .res_ready(res_ready), .res_rd(res_rd), .res_rd_we(res_rd_we),
      .res_data(res_data), .res_illegal(res_illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // csr file seen by the DUT; only this process writes it
   logic [31:0] env_mem [0:4095];
   logic        poke_en;
   logic [11:0] poke_addr;
   logic [31:0] poke_val;
   always @(posedge clk) begin
      if (poke_en) env_mem[poke_addr] <= poke_val;
      else if (csr_we) env_mem[csr_addr] <= csr_wd;
   end
   assign csr_rdata = env_mem[csr_addr];

   logic [31:0] model_mem [0:4095];
   int          vec = 0;
   int          miss = 0;
   int          since = -1;
   int          resp_cyc = 1;
   logic        exp_ill, exp_wneed, exp_rd_we;
   logic [11:0] exp_addr;
   logic [4:0]  exp_rd;
   logic [31:0] exp_old, exp_wd;

   int          we_total = 0;
   logic [31:0] cap_wd = 0, cap_data = 0;
   logic [4:0]  cap_rd = 0;
   logic        cap_rd_we = 0, cap_ill = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec++;
      if (act !== exp) begin
         miss++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("instr_ready", {31'd0, instr_ready}, {31'd0, since < 0});
      chk("csr_we", {31'd0, csr_we}, {31'd0, (since == 2) && !exp_ill && exp_wneed});
      chk("csr_wd", csr_wd, ((since == 2) && !exp_ill && exp_wneed) ? exp_wd : 32'd0);
      chk("res_valid", {31'd0, res_valid}, {31'd0, (since >= resp_cyc)});
      if (since < 0) begin
         chk("idle_illegal", {31'd0, res_illegal}, 32'd0);
         chk("idle_rd_we", {31'd0, res_rd_we}, 32'd0);
      end
      if (since >= 1 && since <= 2 && !exp_ill) chk("csr_addr", {20'd0, csr_addr}, {20'd0, exp_addr});
      if (since >= resp_cyc) begin
         chk("res_data", res_data, exp_old);
         chk("res_rd", {27'd0, res_rd}, {27'd0, exp_rd});
         chk("res_rd_we", {31'd0, res_rd_we}, {31'd0, exp_rd_we});
         chk("res_illegal", {31'd0, res_illegal}, {31'd0, exp_ill});
      end
      if (csr_we) begin
         we_total++;
         cap_wd = csr_wd;
      end
      if (res_valid) begin
         cap_data  = res_data;
         cap_rd    = res_rd;
         cap_rd_we = res_rd_we;
         cap_ill   = res_illegal;
      end
   end

   function automatic logic [31:0] enc(input int f3, input int rd, input int rs, input int csr);
      logic [11:0] c;
      logic [4:0]  r, s;
      logic [2:0]  f;
      c = csr[11:0];
      r = rd[4:0];
      s = rs[4:0];
      f = f3[2:0];
      return {c, s, f, r, 7'b1110011};
   endfunction

   // Instruction-level view: kind 1=swap, 2=set, 3=clear, 0=not a CSR op
   task automatic model(input logic [31:0] ins, input logic [31:0] rs1);
      int          kind;
      logic [31:0] src;
      logic [4:0]  z;
      z        = ins[19:15];
      exp_addr = ins[31:20];
      exp_rd   = ins[11:7];
      src      = ins[14] ? {27'd0, z} : rs1;
      case (ins[14:12])
         3'd1, 3'd5: kind = 1;
         3'd2, 3'd6: kind = 2;
         3'd3, 3'd7: kind = 3;
         default:    kind = 0;
      endcase
      exp_ill   = (ins[6:0] != 7'h73) || (kind == 0);
      exp_wneed = (kind == 1) || (z != 5'd0);
      if (!exp_ill && exp_wneed && exp_addr >= 12'hC00) exp_ill = 1'b1;
      exp_old = exp_ill ? 32'd0 : model_mem[exp_addr];
      if (kind == 1)      exp_wd = src;
      else if (kind == 2) exp_wd = exp_old | src;
      else                exp_wd = exp_old & ~src;
      exp_rd_we = !exp_ill && (exp_rd != 5'd0);
      resp_cyc  = exp_ill ? 1 : 3;
   endtask

   task automatic step();
      @(posedge clk); #1;
      since++;
   endtask

   task automatic poke(input logic [11:0] a, input logic [31:0] v);
      model_mem[a] = v;
      poke_addr = a;
      poke_val  = v;
      poke_en   = 1'b1;
      @(posedge clk); #1;
      poke_en   = 1'b0;
   endtask

   int we_before;

   task automatic run(input logic [31:0] ins, input logic [31:0] rs1, input int stall);
      model(ins, rs1);
      we_before   = we_total;
      instr       = ins;
      rs1_val     = rs1;
      instr_valid = 1'b1;
      res_ready   = 1'b1;
      @(posedge clk); #1;
      instr_valid = 1'b0;
      instr       = 32'hFFFF_FFFF;
      rs1_val     = 32'hA5A5_A5A5;
      since       = 1;
      while (since < resp_cyc) step();
      if (stall > 0) begin
         res_ready = 1'b0;
         repeat (stall) step();
         res_ready = 1'b1;
      end
      @(posedge clk); #1;
      res_ready = 1'b0;
      since     = -1;
      if (!exp_ill && exp_wneed) model_mem[exp_addr] = exp_wd;
      chk("csr_mem", env_mem[exp_addr], model_mem[exp_addr]);
   endtask

   initial begin
      rst = 1'b1; instr_valid = 1'b0; instr = '0; rs1_val = '0; res_ready = 1'b0;
      poke_en = 1'b0; poke_addr = '0; poke_val = '0;
      exp_ill = 0; exp_wneed = 0; exp_rd_we = 0; exp_addr = 0; exp_rd = 0; exp_old = 0; exp_wd = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_csr_addr", {20'd0, csr_addr}, 32'd0);
      chk("rst_res_data", res_data, 32'd0);
      chk("rst_res_rd", {27'd0, res_rd}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      poke(12'h001, 32'h0);
      run(enc(1, 1, 1, 12'h001), 32'd3, 0);
      chk("t1_we_cnt", we_total - we_before, 32'd1);
      chk("t1_wd", cap_wd, 32'd3);
      chk("t1_data", cap_data, 32'd0);
      chk("t1_rd_we", {31'd0, cap_rd_we}, 32'd1);

      poke(12'h300, 32'h00F);
      run(enc(2, 5, 6, 12'h300), 32'h0F0, 1);
      chk("t2_wd", cap_wd, 32'h0FF);
      chk("t2_data", cap_data, 32'h00F);
      chk("t2_rd", {27'd0, cap_rd}, 32'd5);

      poke(12'h340, 32'hFF);
      run(enc(3, 7, 0, 12'h340), 32'h1234, 0);
      chk("t3_we_cnt", we_total - we_before, 32'd0);
      chk("t3_data", cap_data, 32'hFF);

      poke(12'hC00, 32'h00C0_FFEE);
      run(enc(6, 3, 5, 12'hC00), 32'd0, 0);
      chk("t4_ill", {31'd0, cap_ill}, 32'd1);
      chk("t4_we_cnt", we_total - we_before, 32'd0);
      chk("t4_rd_we", {31'd0, cap_rd_we}, 32'd0);

      run(enc(2, 4, 0, 12'hC00), 32'h55, 0);
      chk("t5_ill", {31'd0, cap_ill}, 32'd0);
      chk("t5_data", cap_data, 32'h00C0_FFEE);

      run(enc(0, 8, 0, 12'h300), 32'd0, 4);
      chk("t6_ill", {31'd0, cap_ill}, 32'd1);
      run({12'h001, 5'd1, 3'b001, 5'd2, 7'b0110011}, 32'd9, 4);
      chk("t7_ill", {31'd0, cap_ill}, 32'd1);

      run(enc(7, 9, 5'h0F, 12'h300), 32'd0, 0);
      chk("t8_wd", cap_wd, 32'hF0);
      chk("t8_data", cap_data, 32'hFF);

      poke(12'h305, 32'hAAAA);
      run(enc(5, 0, 5'h1F, 12'h305), 32'd0, 2);
      chk("t9_wd", cap_wd, 32'h1F);
      chk("t9_rd_we", {31'd0, cap_rd_we}, 32'd0);

      run(enc(1, 2, 3, 12'hC01), 32'd7, 0);
      chk("t10_ill", {31'd0, cap_ill}, 32'd1);
      run(enc(4, 2, 3, 12'h300), 32'd7, 0);
      chk("t11_ill", {31'd0, cap_ill}, 32'd1);

      // abort during READ: no write, no result, straight back to IDLE
      poke(12'h340, 32'h77);
      model(enc(1, 1, 2, 12'h340), 32'h99);
      we_before   = we_total;
      instr       = enc(1, 1, 2, 12'h340);
      rs1_val     = 32'h99;
      instr_valid = 1'b1;
      @(posedge clk); #1;
      instr_valid = 1'b0;
      since       = 1;
      rst         = 1'b1;
      @(posedge clk); #1;
      rst   = 1'b0;
      since = -1;
      repeat (3) begin
         @(posedge clk); #1;
      end
      chk("t12_we_cnt", we_total - we_before, 32'd0);
      chk("t12_mem", env_mem[12'h340], 32'h77);

      run(enc(2, 1, 2, 12'h340), 32'h100, 0);
      chk("t13_data", cap_data, 32'h77);
      chk("t13_wd", cap_wd, 32'h177);

      repeat (2) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end

endmodule
